// File: rtl/tx_iq_buffer.sv
// -----------------------------------------------------------------------------
// tx_iq_buffer
//
// Transmit-side I/Q sample buffer between a host writer and a downstream
// interpolator. Words are 32-bit I/Q pairs ([31:16]=I, [15:0]=Q). The buffer is
// a first-word-fall-through FIFO gated by a small controller:
//   IDLE    - buffer accepts writes, nothing is presented for reading
//   PREFILL - waiting until PREFILL words are stored before enabling reads
//   RUN     - the interpolator pops one word per strobe
//   FLUSH   - one-cycle clear of pointers and fill level, then back to IDLE
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   wr_data/wr_en    host write, one word per cycle
//   wr_full          fill_level == DEPTH
//   PTT              transmit enable (level)
//   tsiq_read_strobe interpolator request for the next word
//   tsiq_data        oldest stored word (0 when empty)
//   tsiq_valid       tsiq_data valid in RUN; a strobe this cycle consumes it
//   fill_level       words stored
//   underflow_count  saturating count of strobes that found RUN empty
//   overflow_count   saturating count of writes dropped because full
//   running          high only in RUN
// -----------------------------------------------------------------------------
module tx_iq_buffer #(
  parameter int DEPTH_LOG2 = 10,
  parameter int PREFILL    = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  input  logic                  PTT,
  input  logic                  tsiq_read_strobe,
  output logic [31:0]           tsiq_data,
  output logic                  tsiq_valid,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [15:0]           underflow_count,
  output logic [15:0]           overflow_count,
  output logic                  running
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL   = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PREFILL_LVL = (DEPTH_LOG2+1)'(PREFILL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic [15:0]           underflow_q, underflow_d;
  logic [15:0]           overflow_q, overflow_d;
  logic [31:0]           mem_q [DEPTH];

  logic empty, full, push, pop, drop, starve;

  assign empty = (fill_q == '0);
  assign full  = (fill_q == DEPTH_LVL);

  // A write while full is dropped even if a pop frees a slot the same cycle;
  // writes during FLUSH are discarded silently (not an overflow).
  assign push   = wr_en && !full && (state_q != ST_FLUSH);
  assign drop   = wr_en &&  full && (state_q != ST_FLUSH);
  assign pop    = (state_q == ST_RUN) && tsiq_read_strobe && !empty;
  assign starve = (state_q == ST_RUN) && tsiq_read_strobe &&  empty;

  // Controller next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (PTT) state_d = ST_PREFILL;
      ST_PREFILL: begin
        if (!PTT)                       state_d = ST_FLUSH;
        else if (fill_q >= PREFILL_LVL) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!PTT)        state_d = ST_FLUSH;
        else if (starve) state_d = ST_PREFILL;
      end
      ST_FLUSH:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state logic.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    underflow_d = underflow_q;
    overflow_d  = overflow_q;

    if (state_q == ST_FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      // Pointers wrap naturally at DEPTH; fill_q is one bit wider so full and
      // empty are distinguishable.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      fill_d = fill_q + 1'b1;
      else if (pop && !push) fill_d = fill_q - 1'b1;
    end

    if (starve && underflow_q != 16'hFFFF) underflow_d = underflow_q + 1'b1;
    if (drop   && overflow_q  != 16'hFFFF) overflow_d  = overflow_q  + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state is updated only with non-blocking assignments so
      // every register samples the pre-edge values of the others.
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      underflow_q <= '0;
      overflow_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; stale contents are unreachable
  // because fill_q gates everything read out of it, and leaving it unreset lets
  // it map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Fall-through read: the word written at edge N is visible right after N,
  // and the consumer latches it combinationally in the strobe cycle.
  assign tsiq_data       = empty ? 32'd0 : mem_q[rd_ptr_q];
  assign tsiq_valid      = (state_q == ST_RUN) && !empty;
  assign running         = (state_q == ST_RUN);
  assign wr_full         = full;
  assign fill_level      = fill_q;
  assign underflow_count = underflow_q;
  assign overflow_count  = overflow_q;

endmodule

// File: tb/tb_tx_iq_buffer.sv
// -----------------------------------------------------------------------------
// tb_tx_iq_buffer
//
// Directed bench for tx_iq_buffer with default parameters (DEPTH=1024,
// PREFILL=256). Inputs change 1 time unit after each rising edge and outputs
// are checked there, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_tx_iq_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        wr_full;
  logic        PTT;
  logic        tsiq_read_strobe;
  logic [31:0] tsiq_data;
  logic        tsiq_valid;
  logic [10:0] fill_level;
  logic [15:0] underflow_count;
  logic [15:0] overflow_count;
  logic        running;

  int checks = 0;
  int errors = 0;

  tx_iq_buffer #(.DEPTH_LOG2(10), .PREFILL(256)) dut (
    .clk              (clk),
    .reset            (reset),
    .wr_data          (wr_data),
    .wr_en            (wr_en),
    .wr_full          (wr_full),
    .PTT              (PTT),
    .tsiq_read_strobe (tsiq_read_strobe),
    .tsiq_data        (tsiq_data),
    .tsiq_valid       (tsiq_valid),
    .fill_level       (fill_level),
    .underflow_count  (underflow_count),
    .overflow_count   (overflow_count),
    .running          (running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_fill"},  32'(fill_level), 32'd0);
    check({tag, "_valid"}, 32'(tsiq_valid), 32'd0);
    check({tag, "_data"},  tsiq_data, 32'd0);
    check({tag, "_full"},  32'(wr_full), 32'd0);
    check({tag, "_run"},   32'(running), 32'd0);
    check({tag, "_uflow"}, 32'(underflow_count), 32'd0);
    check({tag, "_oflow"}, 32'(overflow_count), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    wr_data = '0;
    wr_en = 1'b0;
    PTT = 1'b0;
    tsiq_read_strobe = 1'b0;
    #2;
    check_all_reset("reset");
    tick(); tick();
    reset = 1'b1;
    tick();

    // Prefill 256 words, RUN starts the cycle after the last write.
    PTT = 1'b1;
    wr_en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      wr_data = 32'h0001_0000 + 32'(k);
      tick();
    end
    wr_en = 1'b0;
    check("pf_fill256", 32'(fill_level), 32'd256);
    check("pf_run_not_yet", 32'(running), 32'd0);
    check("pf_valid_not_yet", 32'(tsiq_valid), 32'd0);
    tick();
    check("pf_running", 32'(running), 32'd1);
    check("pf_valid", 32'(tsiq_valid), 32'd1);
    tsiq_read_strobe = 1'b1;
    for (int k = 0; k < 256; k++) begin
      check("pf_order", tsiq_data, 32'h0001_0000 + 32'(k));
      tick();
    end
    tsiq_read_strobe = 1'b0;
    check("pf_drained_fill", 32'(fill_level), 32'd0);
    check("pf_drained_valid", 32'(tsiq_valid), 32'd0);
    check("pf_still_run", 32'(running), 32'd1);
    check("pf_no_uflow", 32'(underflow_count), 32'd0);

    // One word in RUN, two consecutive strobes: second one starves.
    wr_en = 1'b1;
    wr_data = 32'hAAAA_5555;
    tick();
    wr_en = 1'b0;
    check("uf_valid1", 32'(tsiq_valid), 32'd1);
    check("uf_data1", tsiq_data, 32'hAAAA_5555);
    tsiq_read_strobe = 1'b1;
    tick();
    check("uf_empty", 32'(fill_level), 32'd0);
    check("uf_cnt0", 32'(underflow_count), 32'd0);
    tick();
    tsiq_read_strobe = 1'b0;
    check("uf_cnt1", 32'(underflow_count), 32'd1);
    check("uf_prefill", 32'(running), 32'd0);
    check("uf_valid0", 32'(tsiq_valid), 32'd0);

    // Fill to 500 words (passes PREFILL into RUN), then drop PTT.
    wr_en = 1'b1;
    for (int k = 0; k < 500; k++) begin
      wr_data = 32'h0004_0000 + 32'(k);
      tick();
    end
    wr_en = 1'b0;
    tick();
    check("fl_run", 32'(running), 32'd1);
    check("fl_fill500", 32'(fill_level), 32'd500);
    PTT = 1'b0;
    tick();
    check("fl_flush_not_run", 32'(running), 32'd0);
    check("fl_flush_fill", 32'(fill_level), 32'd500);
    wr_en = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    check("fl_cleared", 32'(fill_level), 32'd0);
    check("fl_no_oflow", 32'(overflow_count), 32'd0);
    check("fl_data0", tsiq_data, 32'd0);
    tick();
    check("fl_idle_fill", 32'(fill_level), 32'd0);

    // 1025 writes in IDLE: last one overflows.
    wr_en = 1'b1;
    for (int k = 0; k < 1025; k++) begin
      wr_data = 32'h0002_0000 + 32'(k);
      tick();
    end
    wr_en = 1'b0;
    check("of_fill", 32'(fill_level), 32'd1024);
    check("of_full", 32'(wr_full), 32'd1);
    check("of_cnt1", 32'(overflow_count), 32'd1);
    check("of_idle_valid", 32'(tsiq_valid), 32'd0);
    PTT = 1'b1;
    tick();
    tick();
    check("of_run", 32'(running), 32'd1);
    // Full buffer: write and pop in the same cycle -> write still dropped.
    check("of_first", tsiq_data, 32'h0002_0000);
    wr_en = 1'b1;
    wr_data = 32'h0BAD_0BAD;
    tsiq_read_strobe = 1'b1;
    tick();
    wr_en = 1'b0;
    check("of_popfull_fill", 32'(fill_level), 32'd1023);
    check("of_cnt2", 32'(overflow_count), 32'd2);
    check("of_not_full", 32'(wr_full), 32'd0);
    for (int k = 1; k < 1024; k++) begin
      check("of_order", tsiq_data, 32'h0002_0000 + 32'(k));
      tick();
    end
    tsiq_read_strobe = 1'b0;
    check("of_drained", 32'(fill_level), 32'd0);
    check("of_drained_valid", 32'(tsiq_valid), 32'd0);

    // Steady state across pointer wrap: fill 10, write+strobe each cycle.
    wr_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr_data = 32'h0003_0000 + 32'(k);
      tick();
    end
    check("ss_fill10", 32'(fill_level), 32'd10);
    tsiq_read_strobe = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      wr_data = 32'h0003_0000 + 32'(i + 10);
      check("ss_order", tsiq_data, 32'h0003_0000 + 32'(i));
      tick();
    end
    tsiq_read_strobe = 1'b0;
    wr_en = 1'b0;
    check("ss_fill", 32'(fill_level), 32'd10);
    check("ss_uflow", 32'(underflow_count), 32'd1);
    check("ss_oflow", 32'(overflow_count), 32'd2);
    check("ss_run", 32'(running), 32'd1);

    // Reset mid-RUN with 300 words: outputs clear without a clock edge.
    wr_en = 1'b1;
    for (int k = 0; k < 290; k++) begin
      wr_data = 32'h0005_0000 + 32'(k);
      tick();
    end
    wr_en = 1'b0;
    check("rs_fill300", 32'(fill_level), 32'd300);
    #1;
    reset = 1'b0;
    #1;
    check_all_reset("rs_async");
    tick();
    reset = 1'b1;
    tick();
    wr_en = 1'b1;
    wr_data = 32'h7777_7777;
    tick();
    wr_en = 1'b0;
    check("rs_first_fill", 32'(fill_level), 32'd1);
    check("rs_first_data", tsiq_data, 32'h7777_7777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_iq_buffer.md
TX_IQ_BUFFER -- requirements
Module: tx_iq_buffer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the buffer depth in 32-bit I/Q words (DEPTH = 1024).
REQ-002 SHALL have parameter PREFILL, default 256, meaning the words required before reads are enabled; legal range 1..DEPTH.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-005 wr_data  input  32  host I/Q word; [31:16]=I, [15:0]=Q, two's complement.
REQ-006 wr_en  input  1  write request, one word per cycle.
REQ-007 wr_full  output  1  high when fill_level == DEPTH.
REQ-008 PTT  input  1  transmit enable; level-sensitive.
REQ-009 tsiq_read_strobe  input  1  downstream interpolator request for the next word.
REQ-010 tsiq_data  output  32  oldest buffered word, first-word-fall-through.
REQ-011 tsiq_valid  output  1  tsiq_data is valid and a strobe this cycle consumes it.
REQ-012 fill_level  output  DEPTH_LOG2+1  words currently stored.
REQ-013 underflow_count  output  16  saturating count of starved strobes.
REQ-014 overflow_count  output  16  saturating count of dropped writes.
REQ-015 running  output  1  high only in state RUN.

Function
REQ-016 SHALL implement states IDLE, PREFILL, RUN, FLUSH.
REQ-017 IDLE: accept writes; tsiq_valid=0; strobes ignored; PTT=1 -> PREFILL.
REQ-018 PREFILL: accept writes; tsiq_valid=0; fill_level >= PREFILL -> RUN; strobes ignored, not counted.
REQ-019 RUN: tsiq_valid = (fill_level != 0); strobe with tsiq_valid=1 pops one word at that edge.
REQ-020 RUN: strobe with fill_level == 0 -> underflow_count +1 (saturating at 0xFFFF), next state PREFILL.
REQ-021 PTT=0 in PREFILL or RUN -> FLUSH next cycle; FLUSH resets pointers and fill_level to 0 in one cycle, drops any write that cycle, then goes to IDLE.
REQ-022 Write with fill_level == DEPTH SHALL be dropped and overflow_count +1 (saturating), even if a pop occurs the same cycle.
REQ-023 Simultaneous accepted write and pop: fill_level unchanged; both pointers advance.
REQ-024 Write at edge N: fill_level increments at edge N; the word is presentable on tsiq_data from the cycle following edge N (1-cycle write-to-read latency, including the empty-buffer case).
REQ-025 tsiq_data SHALL be stable while tsiq_valid=1 and no pop occurs; after a pop it shows the next word in the following cycle.
REQ-026 tsiq_data SHALL be the word being consumed in the same cycle tsiq_read_strobe & tsiq_valid (the consumer latches combinationally-present data).
REQ-027 Pointers wrap modulo DEPTH; fill_level distinguishes full from empty.
REQ-028 Words SHALL leave in write order with no loss or duplication except as defined by REQ-021 and REQ-022.
REQ-029 Counters clear only on reset.

Reset
REQ-030 On reset=0: state IDLE, fill_level=0, pointers=0, tsiq_valid=0, tsiq_data=0, wr_full=0, running=0, both counters=0; asynchronous assertion, synchronous-safe deassertion.
REQ-031 Reset asserted mid-RUN SHALL discard all stored words; first post-reset write is the next word delivered.

Verification
REQ-032 PTT=1, write 256 words 0x00010000+k -> running rises the cycle after the 256th write; 256 strobes return k=0..255 in order.
REQ-033 RUN with 1 word, strobe on 2 consecutive cycles -> first returns the word, second increments underflow_count to 1, state PREFILL, tsiq_valid=0.
REQ-034 Write 1025 words with PTT=0 -> fill_level=1024, wr_full=1, overflow_count=1; the 1025th word is never delivered.
REQ-035 RUN, drop PTT with 500 words stored -> FLUSH one cycle, then IDLE with fill_level=0; a write during FLUSH is lost.
REQ-036 RUN, fill_level=10, write and strobe every cycle for 2000 cycles -> fill_level stays 10, data in order across pointer wrap, no counter change.
REQ-037 Assert reset mid-RUN with 300 words -> all outputs at REQ-030 values immediately, without a clock edge.
